full_adder_hw_checker: RTL and testbench

//  Synthesizable stimulus generator and response checker for a 1-bit full adder.

---
 rtl/full_adder_hw_checker_if.sv | 31 +++
 rtl/full_adder_hw_checker.sv | 173 +++++++++++++++++
 tb/tb_full_adder_hw_checker.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/full_adder_hw_checker_if.sv
`timescale 1ns/1ps
// Signal bundle between the on-board checker and the external 1-bit full adder it exercises,
// plus the run status that goes to the LEDs.
interface full_adder_hw_checker_if;
   logic        start;
   logic        a;
   logic        b;
   logic        carry_in;
   logic        sum;
   logic        carry_out;
   logic        busy;
   logic        done;
   logic        pass;
   logic        error;
   logic [15:0] vector_count;
   logic [15:0] error_count;
   logic [2:0]  err_vector;
   logic [1:0]  err_result;

   modport master (
      input  start, sum, carry_out,
      output a, b, carry_in, busy, done, pass, error,
             vector_count, error_count, err_vector, err_result
   );

   modport slave (
      output start, sum, carry_out,
      input  a, b, carry_in, busy, done, pass, error,
             vector_count, error_count, err_vector, err_result
   );
endinterface

// File: rtl/full_adder_hw_checker.sv
`timescale 1ns/1ps
// Stimulus generator and response checker for an external 1-bit full adder: drives LFSR
// vectors, waits for the adder to settle, compares against a+b+carry_in and reports.
module full_adder_hw_checker #(
   parameter int          N_VECTORS     = 100,
   parameter int          SETTLE_CYCLES = 2,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter bit          STOP_ON_ERROR = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst,
   full_adder_hw_checker_if.master        bus
);

   // An all-zero Galois LFSR would lock up, so a zero seed is promoted to 1.
   localparam logic [15:0] SEED_EFF    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [15:0] N_LAST      = 16'(N_VECTORS);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] LFSR_MASK   = 16'hB400;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRIVE  = 3'd1,
      SETTLE = 3'd2,
      CHECK  = 3'd3,
      DONE   = 3'd4
   } state_t;

   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      logic [15:0] shifted;
      shifted = {1'b0, cur[15:1]};
      if (cur[0]) begin
         return shifted ^ LFSR_MASK;
      end else begin
         return shifted;
      end
   endfunction

   function automatic logic [1:0] fa_expected(input logic [2:0] vec);
      return {1'b0, vec[2]} + {1'b0, vec[1]} + {1'b0, vec[0]};
   endfunction

   state_t      state_r;
   logic [15:0] lfsr_r;
   logic [15:0] settle_cnt_r;
   logic [1:0]  expected_r;
   logic        a_r;
   logic        b_r;
   logic        carry_in_r;
   logic        busy_r;
   logic        done_r;
   logic        pass_r;
   logic        error_r;
   logic [15:0] vector_count_r;
   logic [15:0] error_count_r;
   logic [2:0]  err_vector_r;
   logic [1:0]  err_result_r;

   logic        mismatch_s;
   logic        last_s;
   logic        finish_s;
   logic [15:0] err_inc_s;

   // Response comparison and end-of-run decision for the CHECK cycle.
   always_comb begin
      mismatch_s = 1'b0;
      last_s     = 1'b0;
      finish_s   = 1'b0;
      err_inc_s  = error_count_r;
      mismatch_s = ({bus.carry_out, bus.sum} != expected_r);
      last_s     = ((vector_count_r + 16'd1) == N_LAST);
      if (error_count_r == 16'hFFFF) begin
         err_inc_s = error_count_r;
      end else begin
         err_inc_s = error_count_r + 16'd1;
      end
      if ((mismatch_s && STOP_ON_ERROR) || last_s) begin
         finish_s = 1'b1;
      end else begin
         finish_s = 1'b0;
      end
   end

   // Run sequencer: all stimulus and status outputs are registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= IDLE;
         lfsr_r         <= SEED_EFF;
         settle_cnt_r   <= 16'd0;
         expected_r     <= 2'b00;
         a_r            <= 1'b0;
         b_r            <= 1'b0;
         carry_in_r     <= 1'b0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         pass_r         <= 1'b0;
         error_r        <= 1'b0;
         vector_count_r <= 16'd0;
         error_count_r  <= 16'd0;
         err_vector_r   <= 3'b000;
         err_result_r   <= 2'b00;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (bus.start) begin
                  state_r        <= DRIVE;
                  busy_r         <= 1'b1;
                  done_r         <= 1'b0;
                  pass_r         <= 1'b0;
                  error_r        <= 1'b0;
                  vector_count_r <= 16'd0;
                  error_count_r  <= 16'd0;
                  err_vector_r   <= 3'b000;
                  err_result_r   <= 2'b00;
               end
            end
            DRIVE: begin
               {a_r, b_r, carry_in_r} <= lfsr_r[2:0];
               expected_r             <= fa_expected(lfsr_r[2:0]);
               lfsr_r                 <= lfsr_next(lfsr_r);
               settle_cnt_r           <= 16'd0;
               state_r                <= SETTLE;
            end
            SETTLE: begin
               if (settle_cnt_r == SETTLE_LAST) begin
                  settle_cnt_r <= 16'd0;
                  state_r      <= CHECK;
               end else begin
                  settle_cnt_r <= settle_cnt_r + 16'd1;
               end
            end
            CHECK: begin
               vector_count_r <= vector_count_r + 16'd1;
               if (mismatch_s) begin
                  error_count_r <= err_inc_s;
                  error_r       <= 1'b1;
                  // Only the first mismatch of a run is captured for diagnosis.
                  if (!error_r) begin
                     err_vector_r <= {a_r, b_r, carry_in_r};
                     err_result_r <= {bus.carry_out, bus.sum};
                  end
               end
               if (finish_s) begin
                  state_r <= DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  pass_r  <= !mismatch_s && (error_count_r == 16'd0);
               end else begin
                  state_r <= DRIVE;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.a            = a_r;
   assign bus.b            = b_r;
   assign bus.carry_in     = carry_in_r;
   assign bus.busy         = busy_r;
   assign bus.done         = done_r;
   assign bus.pass         = pass_r;
   assign bus.error        = error_r;
   assign bus.vector_count = vector_count_r;
   assign bus.error_count  = error_count_r;
   assign bus.err_vector   = err_vector_r;
   assign bus.err_result   = err_result_r;

endmodule

// File: tb/tb_full_adder_hw_checker.sv
`timescale 1ns/1ps
// Bench for full_adder_hw_checker: three checker instances drive behavioural full adders
// (with injectable faults); a bench-side LFSR/arithmetic model predicts every result.
module tb_full_adder_hw_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1, rst2;
   logic sum_stuck0, carry_stuck1;
   int   checks = 0;
   int   errors = 0;

   logic [15:0] m0, m1, m2;
   logic [2:0]  first_run [100];

   full_adder_hw_checker_if bus0 ();
   full_adder_hw_checker_if bus1 ();
   full_adder_hw_checker_if bus2 ();

   assign bus0.sum       = sum_stuck0 ? 1'b0 : (bus0.a ^ bus0.b ^ bus0.carry_in);
   assign bus0.carry_out = (bus0.a & bus0.b) | (bus0.a & bus0.carry_in) | (bus0.b & bus0.carry_in);
   assign bus1.sum       = bus1.a ^ bus1.b ^ bus1.carry_in;
   assign bus1.carry_out = carry_stuck1 ? 1'b0 :
                           ((bus1.a & bus1.b) | (bus1.a & bus1.carry_in) | (bus1.b & bus1.carry_in));
   assign bus2.sum       = bus2.a ^ bus2.b ^ bus2.carry_in;
   assign bus2.carry_out = (bus2.a & bus2.b) | (bus2.a & bus2.carry_in) | (bus2.b & bus2.carry_in);

   full_adder_hw_checker u0 (.clk(clk), .rst(rst0), .bus(bus0.master));
   full_adder_hw_checker #(.STOP_ON_ERROR(1'b0)) u1 (.clk(clk), .rst(rst1), .bus(bus1.master));
   full_adder_hw_checker #(.N_VECTORS(1), .SETTLE_CYCLES(1), .LFSR_SEED(16'h0000))
      u2 (.clk(clk), .rst(rst2), .bus(bus2.master));

   function automatic logic [15:0] model_step(input logic [15:0] l);
      return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic int ones(input logic [2:0] v);
      int n = 0;
      for (int i = 0; i < 3; i++) n += int'(v[i]);
      return n;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
      bus0.start = 1'b0; bus1.start = 1'b0; bus2.start = 1'b0;
      sum_stuck0 = 1'b0; carry_stuck1 = 1'b0;
      tick(2);
      checks++;
      if ({bus0.busy, bus0.done, bus0.pass, bus0.error, bus0.vector_count, bus0.error_count,
           bus0.err_vector, bus0.err_result, bus0.a, bus0.b, bus0.carry_in} !== 44'd0) begin
         errors++; $display("FAIL reset_u0 outputs not all zero");
      end
      checks++;
      if ({bus1.busy, bus1.done, bus1.pass, bus1.error, bus1.vector_count, bus1.error_count} !== 36'd0) begin
         errors++; $display("FAIL reset_u1 outputs not all zero");
      end
      checks++;
      if ({bus2.busy, bus2.done, bus2.pass, bus2.error, bus2.vector_count, bus2.error_count} !== 36'd0) begin
         errors++; $display("FAIL reset_u2 outputs not all zero");
      end
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
      m0 = 16'hACE1; m1 = 16'hACE1; m2 = 16'h0001;
      tick(1);
   endtask

   task automatic test_correct_run();
      logic [2:0] exp;
      tick($urandom_range(0, 5));
      bus0.start = 1'b1; tick(1); bus0.start = 1'b0;
      checks++;
      if (bus0.busy !== 1'b1 || bus0.done !== 1'b0) begin
         errors++; $display("FAIL run_busy got busy=%0b done=%0b want 1 0", bus0.busy, bus0.done);
      end
      for (int v = 0; v < 100; v++) begin
         tick(1);
         exp = m0[2:0];
         first_run[v] = exp;
         checks++;
         if ({bus0.a, bus0.b, bus0.carry_in} !== exp) begin
            errors++; $display("FAIL run_vector[%0d] got %b want %b", v, {bus0.a, bus0.b, bus0.carry_in}, exp);
         end
         m0 = model_step(m0);
         if (v < 99) tick(3);
      end
      tick(2);
      checks++;
      if (bus0.done !== 1'b0 || bus0.busy !== 1'b1) begin
         errors++; $display("FAIL run_early_done got done=%0b busy=%0b at cycle 399", bus0.done, bus0.busy);
      end
      tick(1);
      checks++;
      if ({bus0.done, bus0.busy, bus0.pass, bus0.error} !== 4'b1010) begin
         errors++; $display("FAIL run_status got %b want 1010", {bus0.done, bus0.busy, bus0.pass, bus0.error});
      end
      checks++;
      if (bus0.vector_count !== 16'd100 || bus0.error_count !== 16'd0) begin
         errors++; $display("FAIL run_counts got %0d/%0d want 100/0", bus0.vector_count, bus0.error_count);
      end
   endtask

   task automatic test_stop_on_error();
      logic [15:0] tmp;
      logic [2:0]  fv, v;
      int          k;
      int          stop_idx;
      tmp = m0; k = -1; fv = 3'b000;
      for (int i = 0; i < 100 && k < 0; i++) begin
         v = tmp[2:0];
         tmp = model_step(tmp);
         if (ones(v) % 2 == 1) begin k = i; fv = v; end
      end
      stop_idx = (k >= 0) ? k : 99;
      sum_stuck0 = 1'b1;
      tick($urandom_range(1, 4));
      bus0.start = 1'b1; tick(1); bus0.start = 1'b0;
      checks++;
      if (bus0.done !== 1'b0 || bus0.vector_count !== 16'd0 || bus0.error !== 1'b0) begin
         errors++; $display("FAIL stop_clear got done=%0b vc=%0d err=%0b want 0 0 0", bus0.done, bus0.vector_count, bus0.error);
      end
      for (int i = 0; i <= stop_idx; i++) begin
         tick(1);
         checks++;
         if ({bus0.a, bus0.b, bus0.carry_in} !== m0[2:0]) begin
            errors++; $display("FAIL stop_vector[%0d] got %b want %b", i, {bus0.a, bus0.b, bus0.carry_in}, m0[2:0]);
         end
         m0 = model_step(m0);
         if (i < stop_idx) tick(3);
      end
      tick(2);
      checks++;
      if (bus0.done !== 1'b0) begin
         errors++; $display("FAIL stop_early_done got 1 want 0");
      end
      tick(1);
      checks++;
      if ({bus0.done, bus0.error, bus0.pass} !== {1'b1, k >= 0, k < 0}) begin
         errors++; $display("FAIL stop_status got %b want %b", {bus0.done, bus0.error, bus0.pass}, {1'b1, k >= 0, k < 0});
      end
      checks++;
      if (bus0.vector_count !== 16'(stop_idx + 1) || bus0.error_count !== 16'(k >= 0)) begin
         errors++; $display("FAIL stop_counts got %0d/%0d want %0d/%0d", bus0.vector_count, bus0.error_count, stop_idx + 1, k >= 0);
      end
      checks++;
      if (bus0.err_vector !== fv || bus0.err_result !== {ones(fv) >= 2, 1'b0}) begin
         errors++; $display("FAIL stop_capture got %b/%b want %b/%b", bus0.err_vector, bus0.err_result, fv, {ones(fv) >= 2, 1'b0});
      end
      sum_stuck0 = 1'b0;
   endtask

   task automatic test_no_stop_count();
      logic [15:0] tmp;
      logic [2:0]  v, fv;
      int          ec;
      logic        found;
      tmp = m1; ec = 0; found = 1'b0; fv = 3'b000;
      for (int i = 0; i < 100; i++) begin
         v = tmp[2:0];
         tmp = model_step(tmp);
         if (ones(v) >= 2) begin
            ec++;
            if (!found) begin found = 1'b1; fv = v; end
         end
      end
      carry_stuck1 = 1'b1;
      bus1.start = 1'b1; tick(1); bus1.start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         checks++;
         if ({bus1.a, bus1.b, bus1.carry_in} !== m1[2:0]) begin
            errors++; $display("FAIL count_vector[%0d] got %b want %b", i, {bus1.a, bus1.b, bus1.carry_in}, m1[2:0]);
         end
         m1 = model_step(m1);
         if (i < 99) tick(3);
      end
      tick(3);
      checks++;
      if (bus1.done !== 1'b1 || bus1.vector_count !== 16'd100 || bus1.error_count !== 16'(ec)) begin
         errors++; $display("FAIL count_totals got done=%0b vc=%0d ec=%0d want 1 100 %0d", bus1.done, bus1.vector_count, bus1.error_count, ec);
      end
      checks++;
      if (bus1.error !== found || bus1.pass !== !found) begin
         errors++; $display("FAIL count_flags got error=%0b pass=%0b want %0b %0b", bus1.error, bus1.pass, found, !found);
      end
      checks++;
      if (bus1.err_vector !== fv || bus1.err_result !== {1'b0, ones(fv) % 2 == 1}) begin
         errors++; $display("FAIL count_capture got %b/%b want %b/%b", bus1.err_vector, bus1.err_result, fv, {1'b0, ones(fv) % 2 == 1});
      end
      carry_stuck1 = 1'b0;
   endtask

   task automatic test_midrun_reset();
      bus0.start = 1'b1; tick(1); bus0.start = 1'b0;
      for (int i = 0; i < 37; i++) begin
         tick(1);
         m0 = model_step(m0);
         tick(3);
      end
      checks++;
      if (bus0.vector_count !== 16'd37 || bus0.busy !== 1'b1) begin
         errors++; $display("FAIL mid_count got vc=%0d busy=%0b want 37 1", bus0.vector_count, bus0.busy);
      end
      rst0 = 1'b1;
      #1;
      checks++;
      if ({bus0.busy, bus0.done, bus0.pass, bus0.error, bus0.vector_count, bus0.error_count,
           bus0.err_vector, bus0.err_result, bus0.a, bus0.b, bus0.carry_in} !== 44'd0) begin
         errors++; $display("FAIL mid_reset outputs not all zero");
      end
      tick(1);
      rst0 = 1'b0;
      m0 = 16'hACE1;
      tick(1);
      checks++;
      if (bus0.done !== 1'b0 || bus0.busy !== 1'b0) begin
         errors++; $display("FAIL mid_no_done got done=%0b busy=%0b want 0 0", bus0.done, bus0.busy);
      end
      bus0.start = 1'b1; tick(1); bus0.start = 1'b0;
      for (int v = 0; v < 100; v++) begin
         tick(1);
         checks++;
         if ({bus0.a, bus0.b, bus0.carry_in} !== first_run[v]) begin
            errors++; $display("FAIL replay_vector[%0d] got %b want %b", v, {bus0.a, bus0.b, bus0.carry_in}, first_run[v]);
         end
         m0 = model_step(m0);
         if (v < 99) tick(3);
      end
      tick(3);
      checks++;
      if (bus0.done !== 1'b1 || bus0.pass !== 1'b1 || bus0.vector_count !== 16'd100) begin
         errors++; $display("FAIL replay_status got done=%0b pass=%0b vc=%0d", bus0.done, bus0.pass, bus0.vector_count);
      end
   endtask

   task automatic test_back_to_back();
      int p1, p2;
      p1 = $urandom_range(1, 48);
      p2 = $urandom_range(49, 97);
      bus0.start = 1'b1; tick(1); bus0.start = 1'b0;
      for (int v = 0; v < 100; v++) begin
         tick(1);
         checks++;
         if ({bus0.a, bus0.b, bus0.carry_in} !== m0[2:0]) begin
            errors++; $display("FAIL b2b_vector[%0d] got %b want %b", v, {bus0.a, bus0.b, bus0.carry_in}, m0[2:0]);
         end
         m0 = model_step(m0);
         if (v == p1 || v == p2) begin
            bus0.start = 1'b1; tick(1); bus0.start = 1'b0; tick(2);
         end else if (v < 99) begin
            tick(3);
         end
      end
      tick(2);
      checks++;
      if (bus0.done !== 1'b0) begin
         errors++; $display("FAIL b2b_early_done got 1 want 0");
      end
      tick(1);
      checks++;
      if (bus0.done !== 1'b1 || bus0.vector_count !== 16'd100) begin
         errors++; $display("FAIL b2b_done got done=%0b vc=%0d want 1 100", bus0.done, bus0.vector_count);
      end
      tick($urandom_range(1, 4));
      checks++;
      if (bus0.done !== 1'b1 || bus0.pass !== 1'b1) begin
         errors++; $display("FAIL b2b_hold got done=%0b pass=%0b want 1 1", bus0.done, bus0.pass);
      end
      bus0.start = 1'b1; tick(1); bus0.start = 1'b0;
      checks++;
      if ({bus0.done, bus0.busy, bus0.pass} !== 3'b010 || bus0.vector_count !== 16'd0) begin
         errors++; $display("FAIL b2b_restart got dbp=%b vc=%0d want 010 0", {bus0.done, bus0.busy, bus0.pass}, bus0.vector_count);
      end
      for (int v = 0; v < 100; v++) begin
         tick(1);
         checks++;
         if ({bus0.a, bus0.b, bus0.carry_in} !== m0[2:0]) begin
            errors++; $display("FAIL b2b2_vector[%0d] got %b want %b", v, {bus0.a, bus0.b, bus0.carry_in}, m0[2:0]);
         end
         m0 = model_step(m0);
         if (v < 99) tick(3);
      end
      tick(3);
      checks++;
      if (bus0.done !== 1'b1 || bus0.vector_count !== 16'd100 || bus0.error_count !== 16'd0) begin
         errors++; $display("FAIL b2b2_done got done=%0b vc=%0d ec=%0d", bus0.done, bus0.vector_count, bus0.error_count);
      end
   endtask

   task automatic test_minimal();
      for (int r = 0; r < 2; r++) begin
         bus2.start = 1'b1; tick(1); bus2.start = 1'b0;
         tick(1);
         checks++;
         if ({bus2.a, bus2.b, bus2.carry_in} !== m2[2:0]) begin
            errors++; $display("FAIL min_vector[%0d] got %b want %b", r, {bus2.a, bus2.b, bus2.carry_in}, m2[2:0]);
         end
         m2 = model_step(m2);
         tick(1);
         checks++;
         if (bus2.done !== 1'b0) begin
            errors++; $display("FAIL min_early_done[%0d] got 1 want 0", r);
         end
         tick(1);
         checks++;
         if (bus2.done !== 1'b1 || bus2.pass !== 1'b1 || bus2.vector_count !== 16'd1) begin
            errors++; $display("FAIL min_done[%0d] got done=%0b pass=%0b vc=%0d want 1 1 1", r, bus2.done, bus2.pass, bus2.vector_count);
         end
         tick($urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_correct_run();
      test_stop_on_error();
      test_no_stop_count();
      test_midrun_reset();
      test_back_to_back();
      test_minimal();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
